// File: rtl/res_out_arbiter_pkg.sv
// res_out_arbiter_pkg: shared sizing constants and FSM encoding for the result-FIFO schedulers
package res_out_arbiter_pkg;
    localparam int RES_WORDS = 32;
    localparam int MODEXP_N_UNITS = 4;
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
endpackage

// File: rtl/res_out_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
    parameter int N = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] idx
);
    always_comb begin
        pick = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                pick = '0;
                pick[(int'(ptr) + k) % N] = 1'b1;
                idx = ID_W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/res_out_arbiter.sv
// res_out_arbiter: packet-atomic round-robin write scheduler sharing one result FIFO
module res_out_arbiter
    import res_out_arbiter_pkg::*;
#(
    parameter int N_REQ = MODEXP_N_UNITS,
    parameter int DATA_WIDTH = 32,
    parameter int WORDS_PER_RES = RES_WORDS,
    parameter int CNT_W = $clog2(WORDS_PER_RES + 1),
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] src_data,
    input  logic [N_REQ-1:0]            src_valid,
    output logic [N_REQ-1:0]            src_ready,
    output logic [N_REQ-1:0]            grant,
    output logic [ID_W-1:0]             grant_id,
    output logic [DATA_WIDTH-1:0]       fifo_din,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    output logic                        res_done,
    output logic                        busy
);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  pick;
    logic [ID_W-1:0]   pick_idx;
    logic              xfer;
    logic              last;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    always_comb begin
        xfer = state == XFER;
        busy = xfer;
        src_ready = (xfer && !fifo_full) ? grant : '0;
        fifo_wr_en = xfer & src_valid[grant_id] & ~fifo_full;
        fifo_din = fifo_wr_en ? src_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
        last = cnt == CNT_W'(WORDS_PER_RES - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            grant_id <= '0;
            cnt <= '0;
            rr_ptr <= '0;
            res_done <= 1'b0;
        end else begin
            res_done <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    grant <= pick;
                    grant_id <= pick_idx;
                    cnt <= '0;
                    state <= XFER;
                end
            end else if (fifo_wr_en) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    state <= IDLE;
                    grant <= '0;
                    res_done <= 1'b1;
                    rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_res_out_arbiter.sv
// tb_res_out_arbiter: directed checks of grant order, packet atomicity, backpressure and reset
module tb_res_out_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]  src_valid = '0;
    logic [N-1:0]  src_ready;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic [DW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full = 1'b0;
    logic          res_done;
    logic          busy;

    int widx[N];
    logic [DW-1:0] cap[0:255];
    int ncap = 0;
    int viol = 0;
    int tests = 0;
    int fails = 0;
    int base;

    res_out_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .WORDS_PER_RES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .grant      (grant),
        .grant_id   (grant_id),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .res_done   (res_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) src_data[i*DW +: DW] = {16'(i), 16'(widx[i])};
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (clr) widx[i] <= 0;
            else if (src_valid[i] && src_ready[i]) widx[i] <= widx[i] + 1;
        end
        if (fifo_wr_en) begin
            cap[ncap] <= fifo_din;
            ncap <= ncap + 1;
            if (fifo_full) viol <= viol + 1;
        end
        if ($countones(grant) > 1) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b1;
        req = '0;
        src_valid = '0;
        fifo_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!res_done && c < budget) begin
            step();
            c++;
        end
        chk("done_timeout", 64'(res_done), 64'd1);
    endtask

    task automatic chk_words(input int b, input int p, input int k0, input int n);
        for (int j = 0; j < n; j++) chk("word", 64'(cap[b+j]), 64'({16'(p), 16'(k0 + j)}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(res_done), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_din", 64'(fifo_din), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);

        // single producer, exact latency
        base = ncap;
        req = 4'b0001;
        src_valid = 4'b0001;
        step();
        chk("t1_grant", 64'(grant), 64'b0001);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_wr_en", 64'(fifo_wr_en), 64'd1);
        chk("t1_din", 64'(fifo_din), 64'h0000_0000);
        req = '0;
        repeat (4) step();
        chk("t1_done", 64'(res_done), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_grant_after", 64'(grant), 64'd0);
        step();
        chk("t1_done_pulse", 64'(res_done), 64'd0);
        chk("t1_count", 64'(ncap - base), 64'd4);
        chk_words(base, 0, 0, 4);

        // all requesting from pointer 0
        do_reset();
        base = ncap;
        req = 4'b1111;
        src_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            step();
            chk("t2_grant", 64'(grant), 64'(1 << order[b]));
            wait_done(20);
            chk("t2_grant_id_held", 64'(grant_id), 64'(order[b]));
            chk("t2_idle", 64'(busy), 64'd0);
            if (b == 3) req = 4'b0001;
            if (b == 4) req = 4'b0000;
        end
        chk("t2_count", 64'(ncap - base), 64'd20);
        for (int b = 0; b < 5; b++) chk_words(base + 4*b, order[b], (b == 4) ? 4 : 0, 4);

        // fifo_full held mid-burst
        do_reset();
        base = ncap;
        req = 4'b0001;
        src_valid = 4'b0001;
        step();
        step();
        step();
        chk("t3_two_words", 64'(ncap - base), 64'd2);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_wr_en_full", 64'(fifo_wr_en), 64'd0);
            chk("t3_ready_full", 64'(src_ready), 64'd0);
            step();
        end
        chk("t3_hold_count", 64'(ncap - base), 64'd2);
        fifo_full = 1'b0;
        #1;
        chk("t3_ready_resume", 64'(src_ready), 64'b0001);
        wait_done(20);
        chk("t3_count", 64'(ncap - base), 64'd4);
        chk_words(base, 0, 0, 4);

        // valid gaps and req dropped mid-packet
        do_reset();
        base = ncap;
        req = 4'b0010;
        src_valid = 4'b0010;
        step();
        chk("t4_grant", 64'(grant), 64'b0010);
        for (int c = 0; c < 20; c++) begin
            src_valid[1] = (c % 2 == 0);
            if (ncap - base >= 1) req = '0;
            step();
            if (res_done) break;
            chk("t4_grant_held", 64'(grant), 64'b0010);
        end
        chk("t4_done", 64'(res_done), 64'd1);
        chk("t4_count", 64'(ncap - base), 64'd4);
        chk_words(base, 1, 0, 4);
        src_valid = '0;

        // reset during transfer
        do_reset();
        req = 4'b0100;
        src_valid = 4'b0100;
        step();
        step();
        step();
        rst = 1'b1;
        clr = 1'b1;
        step();
        rst = 1'b0;
        clr = 1'b0;
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(res_done), 64'd0);
        chk("t5_wr_en", 64'(fifo_wr_en), 64'd0);
        base = ncap;
        step();
        chk("t5_regrant", 64'(grant), 64'b0100);
        wait_done(20);
        chk("t5_count", 64'(ncap - base), 64'd4);
        chk_words(base, 2, 0, 4);
        req = '0;
        src_valid = '0;
        step();

        chk("protocol_violations", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
